imem_port_ctrl: RTL and testbench
=================================

// Module: imem_port_ctrl
// PURPOSE
//  Memory-side responder for the instruction-fetch strobes (im_cs/im_wr/im_rd) issued by the PC control unit.
//  Converts each accepted strobe into a req/ack transaction on a variable-latency instruction store.
//  Returns the fetched word to the IF/ID register and raises im_busy, which the hazard unit ORs into Stall.
//  Discards in-flight reads when the PC is redirected (pc_ld), and guards against a hung store with a timeout.
// PARAMETERS
//  ADDR_W   32   byte-address width of pc_addr
//  DATA_W   32   instruction/data word width
//  TO_W     8    timeout counter width
//  TIMEOUT  255  wait cycles before abort; 0 disables the timeout
// PORTS
//  clk        in   1          system clock, rising edge
//  reset_n    in   1          asynchronous, active-low reset
//  im_cs      in   1          chip select from the PC control unit
//  im_wr      in   1          write strobe (boot/self-modify load)
//  im_rd      in   1          read strobe
//  pc_ld      in   1          PC redirect (jump/branch/ISR); flushes in-flight read
//  pc_addr    in   ADDR_W     byte address of the access
//  im_wdata   in   DATA_W     write data
//  im_inst    out  DATA_W     fetched instruction, held until next valid read
//  im_valid   out  1          1-cycle pulse: im_inst updated
//  im_busy    out  1          transaction outstanding (stall request)
//  im_err     out  1          sticky: timeout occurred
//  im_misalign out 1          1-cycle pulse: pc_addr[1:0]!=0, access rejected
//  mem_req    out  1          store request, held until ack
//  mem_we     out  1          store write enable, valid with mem_req
//  mem_addr   out  ADDR_W-2   word address = pc_addr[ADDR_W-1:2]
//  mem_wdata  out  DATA_W     store write data
//  mem_rdata  in   DATA_W     store read data, valid with mem_ack
//  mem_ack    in   1          store completion, 1 cycle per request
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; every output=0, including im_inst. im_err is cleared only by reset.
//  FSM states: IDLE, RD_WAIT, WR_WAIT, DISCARD.
//  IDLE, im_cs=1 sampled at edge:
//   - pc_addr[1:0]!=0 -> im_misalign=1 next cycle; no request; stay IDLE.
//   - im_wr=1 (write wins over rd) -> WR_WAIT, mem_req=1, mem_we=1, latch addr/wdata.
//   - else im_rd=1 -> RD_WAIT, mem_req=1, mem_we=0, latch addr.
//   - cs=1 with wr=rd=0 -> no action.
//  im_cs=0 -> stay IDLE. pc_ld in IDLE is ignored; pc_addr already carries the target.
//  mem_req/mem_we/mem_addr/mem_wdata are registered and stable until the edge where mem_ack=1 is sampled.
//  At that edge mem_req/mem_we drop.
//  RD_WAIT, ack -> im_inst<=mem_rdata, im_valid=1 for 1 cycle, IDLE. Minimum latency: cs edge N, valid after N+1.
//  WR_WAIT, ack -> IDLE, no im_valid.
//  RD_WAIT, pc_ld=1 and ack=0 -> DISCARD; mem_req stays high until ack.
//  RD_WAIT, pc_ld=1 and ack=1 at the same edge -> data dropped, no im_valid, IDLE.
//  DISCARD, ack -> IDLE; rdata dropped; im_inst unchanged.
//  pc_ld in WR_WAIT has no effect; writes always complete.
//  im_busy = (state!=IDLE), combinational. It is 0 in the im_valid cycle, so back-to-back fetch is legal.
//  Timeout: counter cleared on entering any wait state and incremented each wait cycle without ack.
//   - When count==TIMEOUT and no ack: drop mem_req, set im_err, go IDLE; no im_valid.
//   - A late ack arriving in IDLE is ignored.
//   - Counter saturates, never wraps. TIMEOUT=0 disables the check.
//  Ack sampled outside any wait state is ignored.
// TESTING
//  T1 reset: reset_n=0 mid-RD_WAIT -> all outputs 0 immediately; after release, state IDLE and busy=0.
//  T2 read: cs=1,rd=1,addr=0x0000_0010; ack 3 cycles later with rdata=0x2002_0005 -> mem_addr=0x4;
//     busy=1 for 3 cycles; im_inst=0x2002_0005 with one valid pulse.
//  T3 redirect: read in flight, pc_ld=1 at wait cycle 1, ack at cycle 4 with rdata=0xDEAD_BEEF
//     -> no valid, im_inst unchanged; next fetch at the new PC succeeds.
//  T4 write priority + misalign: cs=1,wr=1,rd=1,addr=0x20,wdata=0x1234 -> mem_we=1, mem_addr=0x8;
//     then addr=0x22 -> im_misalign pulse, mem_req never asserted.
//  T5 timeout: TIMEOUT=4, no ack -> mem_req drops after 4 wait cycles; im_err=1 sticky;
//     a following read with ack completes normally.
//  T6 back-to-back: ack=1 same cycle as req on 4 consecutive reads -> 4 valid pulses in 8 cycles,
//     data in issue order.

Source files
------------

// File: rtl/imem_port_ctrl.sv
// rtl/imem_port_ctrl.sv - instruction-fetch strobe responder driving a req/ack instruction store
// Handles fetch/load strobes, PC-redirect flush of in-flight reads, and a saturating hung-store timeout.
module imem_port_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TO_W    = 8,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              im_cs,
   input  logic              im_wr,
   input  logic              im_rd,
   input  logic              pc_ld,
   input  logic [ADDR_W-1:0] pc_addr,
   input  logic [DATA_W-1:0] im_wdata,
   output logic [DATA_W-1:0] im_inst,
   output logic              im_valid,
   output logic              im_busy,
   output logic              im_err,
   output logic              im_misalign,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2,
      DISCARD = 2'd3
   } state_t;

   localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

   state_t          state, state_nxt;
   logic [TO_W-1:0] to_cnt, to_cnt_nxt, to_inc;
   logic            timed_out;
   logic            mem_req_nxt, mem_we_nxt;
   logic            im_valid_nxt, im_misalign_nxt, im_err_nxt;
   logic            load_cmd, load_inst;

   // to_inc is the number of wait cycles completed once this one ends without ack
   assign to_inc    = (to_cnt == {TO_W{1'b1}}) ? to_cnt : to_cnt + 1'b1;
   assign timed_out = (TIMEOUT != 0) && (to_inc == TO_LIM);
   assign im_busy   = (state != IDLE);

   always_comb begin
      state_nxt       = state;
      to_cnt_nxt      = to_cnt;
      mem_req_nxt     = mem_req;
      mem_we_nxt      = mem_we;
      im_valid_nxt    = 1'b0;
      im_misalign_nxt = 1'b0;
      im_err_nxt      = im_err;
      load_cmd        = 1'b0;
      load_inst       = 1'b0;

      case (state)
         IDLE: begin
            if (im_cs) begin
               if (pc_addr[1:0] != 2'b00) begin
                  im_misalign_nxt = 1'b1;
               end else if (im_wr) begin
                  state_nxt   = WR_WAIT;
                  mem_req_nxt = 1'b1;
                  mem_we_nxt  = 1'b1;
                  load_cmd    = 1'b1;
                  to_cnt_nxt  = '0;
               end else if (im_rd) begin
                  state_nxt   = RD_WAIT;
                  mem_req_nxt = 1'b1;
                  mem_we_nxt  = 1'b0;
                  load_cmd    = 1'b1;
                  to_cnt_nxt  = '0;
               end
            end
         end

         RD_WAIT: begin
            if (mem_ack) begin
               state_nxt   = IDLE;
               mem_req_nxt = 1'b0;
               mem_we_nxt  = 1'b0;
               // a redirect on the completing edge makes the returned word stale
               if (!pc_ld) begin
                  load_inst    = 1'b1;
                  im_valid_nxt = 1'b1;
               end
            end else if (timed_out) begin
               state_nxt   = IDLE;
               mem_req_nxt = 1'b0;
               mem_we_nxt  = 1'b0;
               im_err_nxt  = 1'b1;
            end else if (pc_ld) begin
               state_nxt  = DISCARD;
               to_cnt_nxt = '0;
            end else begin
               to_cnt_nxt = to_inc;
            end
         end

         WR_WAIT, DISCARD: begin
            if (mem_ack) begin
               state_nxt   = IDLE;
               mem_req_nxt = 1'b0;
               mem_we_nxt  = 1'b0;
            end else if (timed_out) begin
               state_nxt   = IDLE;
               mem_req_nxt = 1'b0;
               mem_we_nxt  = 1'b0;
               im_err_nxt  = 1'b1;
            end else begin
               to_cnt_nxt = to_inc;
            end
         end

         default: begin
            state_nxt   = IDLE;
            mem_req_nxt = 1'b0;
            mem_we_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         to_cnt      <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         im_inst     <= '0;
         im_valid    <= 1'b0;
         im_err      <= 1'b0;
         im_misalign <= 1'b0;
      end else begin
         state       <= state_nxt;
         to_cnt      <= to_cnt_nxt;
         mem_req     <= mem_req_nxt;
         mem_we      <= mem_we_nxt;
         im_valid    <= im_valid_nxt;
         im_err      <= im_err_nxt;
         im_misalign <= im_misalign_nxt;
         if (load_cmd) begin
            mem_addr <= pc_addr[ADDR_W-1:2];
            if (im_wr) begin
               mem_wdata <= im_wdata;
            end
         end
         if (load_inst) begin
            im_inst <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_imem_port_ctrl.sv
// tb/tb_imem_port_ctrl.sv - scoreboard bench for imem_port_ctrl
// Stimulus queues expected requests, responses and probes; one monitor process compares them all.
module tb_imem_port_ctrl;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int TO_W    = 8;
   localparam int TIMEOUT = 4;

   localparam int S_ZERO    = 0;
   localparam int S_BUSY    = 1;
   localparam int S_ERR     = 2;
   localparam int S_REQ     = 3;
   localparam int S_WE      = 4;
   localparam int S_INST    = 5;
   localparam int S_BUSYCNT = 6;
   localparam int S_VALCNT  = 7;
   localparam int S_LEFT    = 8;
   localparam int S_CLR     = 9;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              im_cs, im_wr, im_rd, pc_ld;
   logic [ADDR_W-1:0] pc_addr;
   logic [DATA_W-1:0] im_wdata;
   logic [DATA_W-1:0] im_inst;
   logic              im_valid, im_busy, im_err, im_misalign;
   logic              mem_req, mem_we;
   logic [ADDR_W-3:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   typedef struct {
      logic        we;
      logic [29:0] addr;
      logic [31:0] wdata;
   } req_t;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } probe_t;

   req_t        exp_req[$];
   logic [31:0] exp_rsp[$];
   int          exp_mis[$];
   probe_t      probes[$];

   int n_vec = 0;
   int n_bad = 0;
   int busy_cnt = 0;
   int valid_cnt = 0;

   imem_port_ctrl #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .TO_W   (TO_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .im_cs      (im_cs),
      .im_wr      (im_wr),
      .im_rd      (im_rd),
      .pc_ld      (pc_ld),
      .pc_addr    (pc_addr),
      .im_wdata   (im_wdata),
      .im_inst    (im_inst),
      .im_valid   (im_valid),
      .im_busy    (im_busy),
      .im_err     (im_err),
      .im_misalign(im_misalign),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack)
   );

   always #5 clk = ~clk;

   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // monitor: all comparisons happen here, at the falling edge
   initial begin : monitor
      logic        prev_req;
      req_t        r;
      probe_t      p;
      logic [31:0] e;
      logic [31:0] act;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         if (im_busy === 1'b1) busy_cnt++;
         if (im_valid === 1'b1) begin
            valid_cnt++;
            if (exp_rsp.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL unexpected_valid: im_inst=%h with no fetch expected", im_inst);
            end else begin
               e = exp_rsp.pop_front();
               compare("rsp_inst", im_inst, e);
            end
         end
         if (mem_req === 1'b1 && prev_req !== 1'b1) begin
            if (exp_req.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL unexpected_req: mem_addr=%h mem_we=%b with no request expected", mem_addr, mem_we);
            end else begin
               r = exp_req.pop_front();
               compare("req_we", {31'b0, mem_we}, {31'b0, r.we});
               compare("req_addr", {2'b0, mem_addr}, {2'b0, r.addr});
               if (r.we) compare("req_wdata", mem_wdata, r.wdata);
            end
         end
         prev_req = mem_req;
         if (im_misalign === 1'b1) begin
            if (exp_mis.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL unexpected_misalign: pulse with none expected");
            end else begin
               void'(exp_mis.pop_front());
               n_vec++;
            end
         end
         while (probes.size() > 0) begin
            p = probes.pop_front();
            act = '0;
            case (p.sel)
               S_ZERO:    act = {31'b0, |{im_inst, im_valid, im_busy, im_err, im_misalign,
                                          mem_req, mem_we, mem_addr, mem_wdata}};
               S_BUSY:    act = {31'b0, im_busy};
               S_ERR:     act = {31'b0, im_err};
               S_REQ:     act = {31'b0, mem_req};
               S_WE:      act = {31'b0, mem_we};
               S_INST:    act = im_inst;
               S_BUSYCNT: act = busy_cnt;
               S_VALCNT:  act = valid_cnt;
               S_LEFT:    act = exp_req.size() + exp_rsp.size() + exp_mis.size();
               default:   act = '0;
            endcase
            if (p.sel == S_CLR) begin
               busy_cnt  = 0;
               valid_cnt = 0;
            end else begin
               compare(p.name, act, p.exp);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic probe(input string name, input int sel, input logic [31:0] exp);
      probe_t p;
      p.name = name;
      p.sel  = sel;
      p.exp  = exp;
      probes.push_back(p);
   endtask

   task automatic expect_req(input logic we, input logic [29:0] waddr, input logic [31:0] wd);
      req_t r;
      r.we    = we;
      r.addr  = waddr;
      r.wdata = wd;
      exp_req.push_back(r);
   endtask

   task automatic issue(input logic wr, input logic rd, input logic [31:0] addr, input logic [31:0] wd);
      im_cs    = 1'b1;
      im_wr    = wr;
      im_rd    = rd;
      pc_addr  = addr;
      im_wdata = wd;
      tick();
      im_cs = 1'b0;
      im_wr = 1'b0;
      im_rd = 1'b0;
   endtask

   // ack is sampled k edges after the issuing edge
   task automatic ack_after(input int k, input logic [31:0] d);
      repeat (k - 1) tick();
      mem_ack   = 1'b1;
      mem_rdata = d;
      tick();
      mem_ack = 1'b0;
   endtask

   logic [31:0] t6_data [4];

   initial begin : stimulus
      t6_data[0] = 32'hA000_0001;
      t6_data[1] = 32'hB000_0002;
      t6_data[2] = 32'hC000_0003;
      t6_data[3] = 32'hD000_0004;

      reset_n   = 1'b0;
      im_cs     = 1'b0;
      im_wr     = 1'b0;
      im_rd     = 1'b0;
      pc_ld     = 1'b0;
      pc_addr   = '0;
      im_wdata  = '0;
      mem_rdata = '0;
      mem_ack   = 1'b0;
      tick();
      probe("reset_outputs", S_ZERO, 32'd0);
      tick();
      reset_n = 1'b1;
      tick();

      // T1: reset in the middle of a read
      expect_req(1'b0, 30'h1, 32'd0);
      issue(1'b0, 1'b1, 32'h0000_0004, 32'd0);
      probe("t1_busy_in_wait", S_BUSY, 32'd1);
      tick();
      reset_n = 1'b0;
      #1;
      probe("t1_reset_outputs", S_ZERO, 32'd0);
      tick();
      reset_n = 1'b1;
      probe("t1_busy_after", S_BUSY, 32'd0);
      tick();
      probe("t1_req_after", S_REQ, 32'd0);
      tick();

      // T2: plain read, ack three edges after issue
      probe("clr", S_CLR, 32'd0);
      expect_req(1'b0, 30'h4, 32'd0);
      exp_rsp.push_back(32'h2002_0005);
      issue(1'b0, 1'b1, 32'h0000_0010, 32'd0);
      ack_after(3, 32'h2002_0005);
      probe("t2_busy_cycles", S_BUSYCNT, 32'd3);
      probe("t2_inst", S_INST, 32'h2002_0005);
      tick();

      // T3: redirect while the read is in flight
      expect_req(1'b0, 30'h10, 32'd0);
      issue(1'b0, 1'b1, 32'h0000_0040, 32'd0);
      pc_ld = 1'b1;
      tick();
      pc_ld = 1'b0;
      probe("t3_busy_discard", S_BUSY, 32'd1);
      ack_after(3, 32'hDEAD_BEEF);
      probe("t3_inst_kept", S_INST, 32'h2002_0005);
      probe("t3_busy_done", S_BUSY, 32'd0);
      probe("t3_err", S_ERR, 32'd0);
      tick();
      expect_req(1'b0, 30'h40, 32'd0);
      exp_rsp.push_back(32'h1111_2222);
      issue(1'b0, 1'b1, 32'h0000_0100, 32'd0);
      ack_after(2, 32'h1111_2222);
      probe("t3_new_pc_inst", S_INST, 32'h1111_2222);
      tick();

      // T4: write wins over read, then a misaligned access
      expect_req(1'b1, 30'h8, 32'h0000_1234);
      issue(1'b1, 1'b1, 32'h0000_0020, 32'h0000_1234);
      probe("t4_we", S_WE, 32'd1);
      ack_after(2, 32'd0);
      probe("t4_busy_done", S_BUSY, 32'd0);
      probe("t4_we_drop", S_WE, 32'd0);
      tick();
      exp_mis.push_back(1);
      issue(1'b0, 1'b1, 32'h0000_0022, 32'd0);
      probe("t4_misalign_noreq", S_REQ, 32'd0);
      tick();
      probe("t4_misalign_idle", S_BUSY, 32'd0);
      tick();

      // T5: hung store, then a late ack, then a normal read
      expect_req(1'b0, 30'h20, 32'd0);
      issue(1'b0, 1'b1, 32'h0000_0080, 32'd0);
      repeat (3) tick();
      probe("t5_req_held", S_REQ, 32'd1);
      tick();
      probe("t5_req_dropped", S_REQ, 32'd0);
      probe("t5_err_set", S_ERR, 32'd1);
      probe("t5_busy_clear", S_BUSY, 32'd0);
      mem_ack   = 1'b1;
      mem_rdata = 32'h5555_AAAA;
      tick();
      mem_ack = 1'b0;
      probe("t5_late_ack_inst", S_INST, 32'h1111_2222);
      tick();
      expect_req(1'b0, 30'h21, 32'd0);
      exp_rsp.push_back(32'hCAFE_F00D);
      issue(1'b0, 1'b1, 32'h0000_0084, 32'd0);
      ack_after(1, 32'hCAFE_F00D);
      probe("t5_after_inst", S_INST, 32'hCAFE_F00D);
      probe("t5_err_sticky", S_ERR, 32'd1);
      tick();

      // T6: four back-to-back reads with same-cycle ack
      probe("clr", S_CLR, 32'd0);
      for (int i = 0; i < 4; i++) begin
         expect_req(1'b0, 30'h80 + 30'(i), 32'd0);
         exp_rsp.push_back(t6_data[i]);
         im_cs   = 1'b1;
         im_rd   = 1'b1;
         pc_addr = 32'h0000_0200 + 32'(4 * i);
         tick();
         mem_ack   = 1'b1;
         mem_rdata = t6_data[i];
         tick();
         mem_ack = 1'b0;
      end
      im_cs = 1'b0;
      im_rd = 1'b0;
      probe("t6_valid_in_8", S_VALCNT, 32'd4);
      probe("t6_last_inst", S_INST, 32'hD000_0004);
      repeat (2) tick();

      probe("leftover_expectations", S_LEFT, 32'd0);
      repeat (2) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
